// File: rtl/red_seq.sv
// Multi-cycle lane reduction: sums all LANE_W-bit lanes of rs and rt through one shared adder,
// with signed/unsigned lanes, optional accumulation into rd, and an overflow flag.
module red_seq #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  rd,
    output logic              ovf
);
    localparam int LANES = DATA_W / LANE_W;
    localparam int SUM_W = LANE_W + $clog2(2 * LANES) + 1;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    // Two guard bits above the wider of acc and rd keep acc + rd exact in either mode.
    localparam int RES_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         rs_q;
    logic [DATA_W-1:0]         rt_q;
    logic                      sgn_q;
    logic                      acc_en_q;
    logic signed [SUM_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic signed [RES_W-1:0]   res;

    function automatic logic signed [SUM_W-1:0] ext_lane(input logic [LANE_W-1:0] lane,
                                                         input logic sgn);
        ext_lane = {{(SUM_W - LANE_W){sgn & lane[LANE_W-1]}}, lane};
    endfunction

    function automatic logic signed [RES_W-1:0] widen_rd(input logic [OUT_W-1:0] val,
                                                         input logic sgn);
        widen_rd = {{(RES_W - OUT_W){sgn & val[OUT_W-1]}}, val};
    endfunction

    function automatic logic out_of_range(input logic signed [RES_W-1:0] r, input logic sgn);
        if (sgn)
            out_of_range = !((&r[RES_W-1:OUT_W-1]) || !(|r[RES_W-1:OUT_W-1]));
        else
            out_of_range = |r[RES_W-1:OUT_W];
    endfunction

    // acc never sets its MSB in unsigned mode, so sign extension is correct for both modes.
    always_comb begin
        res = {{(RES_W - SUM_W){acc[SUM_W-1]}}, acc};
        if (acc_en_q)
            res = res + widen_rd(rd, sgn_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rd    <= '0;
            ovf   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rs_q     <= rs;
                        rt_q     <= rt;
                        sgn_q    <= signed_mode;
                        acc_en_q <= acc_en;
                        acc      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    // Operands shift down so the active lane is always the low lane.
                    acc  <= acc + ext_lane(rs_q[LANE_W-1:0], sgn_q)
                                + ext_lane(rt_q[LANE_W-1:0], sgn_q);
                    rs_q <= rs_q >> LANE_W;
                    rt_q <= rt_q >> LANE_W;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST)
                        state <= FIN;
                end
                FIN: begin
                    rd    <= res[OUT_W-1:0];
                    ovf   <= out_of_range(res, sgn_q);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_red_seq.sv
// Randomized bench for red_seq: cycle-level reference model plus directed cases for
// the default, OUT_W=9 and DATA_W=32 configurations.
module tb_red_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, signed_mode = 1'b0, acc_en = 1'b0;
    logic [15:0] rs = '0, rt = '0;
    logic busy, done, ovf;
    logic [15:0] rd;

    logic start9 = 1'b0;
    logic [15:0] rs9 = '0, rt9 = '0;
    logic busy9, done9, ovf9;
    logic [8:0] rd9;

    logic start32 = 1'b0;
    logic [31:0] rs32 = '0, rt32 = '0;
    logic busy32, done32, ovf32;
    logic [15:0] rd32;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    red_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
                 .acc_en(acc_en), .rs(rs), .rt(rt), .busy(busy), .done(done),
                 .rd(rd), .ovf(ovf));

    red_seq #(.DATA_W(16), .LANE_W(8), .OUT_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .signed_mode(1'b0), .acc_en(1'b0),
        .rs(rs9), .rt(rt9), .busy(busy9), .done(done9), .rd(rd9), .ovf(ovf9));

    red_seq #(.DATA_W(32), .LANE_W(8), .OUT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(1'b0), .acc_en(1'b0),
        .rs(rs32), .rt(rt32), .busy(busy32), .done(done32), .rd(rd32), .ovf(ovf32));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact integer sum of all lanes (plus prior rd if accumulating), then wrap and range test.
    function automatic void ref_op(input logic [63:0] a, input logic [63:0] b, input int lanes,
                                   input int lw, input int ow, input bit sgn, input bit accen,
                                   input logic [31:0] prev, output logic [31:0] r, output bit o);
        longint sum, v, lmask, omask;
        sum = 0;
        lmask = (longint'(1) << lw) - 1;
        omask = (longint'(1) << ow) - 1;
        for (int i = 0; i < lanes; i++) begin
            v = longint'(a >> (i * lw)) & lmask;
            if (sgn && v >= (longint'(1) << (lw - 1))) v -= longint'(1) << lw;
            sum += v;
            v = longint'(b >> (i * lw)) & lmask;
            if (sgn && v >= (longint'(1) << (lw - 1))) v -= longint'(1) << lw;
            sum += v;
        end
        if (accen) begin
            v = longint'(prev) & omask;
            if (sgn && v >= (longint'(1) << (ow - 1))) v -= longint'(1) << ow;
            sum += v;
        end
        r = 32'(sum & omask);
        if (sgn) o = (sum < -(longint'(1) << (ow - 1))) || (sum > (longint'(1) << (ow - 1)) - 1);
        else     o = (sum < 0) || (sum > omask);
    endfunction

    // Reference timing: an accepted start counts down LANES+1 edges to completion.
    int m_left = 0;
    bit m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_rd = '0;
    logic [15:0] m_rs, m_rt;
    bit m_sgn, m_acc;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_busy = 0; m_done = 0; m_rd = '0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_left == 0) begin
                if (start) begin
                    m_rs = rs; m_rt = rt; m_sgn = signed_mode; m_acc = acc_en;
                    m_left = 3;
                    m_busy = 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    ref_op(64'(m_rs), 64'(m_rt), 2, 8, 16, m_sgn, m_acc, m_rd, m_rd, m_ovf);
                    m_rd = m_rd & 32'hFFFF;
                    m_done = 1;
                    m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("rd", 64'(rd), 64'(m_rd[15:0]));
            check("ovf", 64'(ovf), 64'(m_ovf));
            check("busy_done_excl", 64'(busy & done), 64'(0));
        end
    end

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit s, input bit ac);
        rs = a; rt = b; signed_mode = s; acc_en = ac; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs = 16'($urandom); rt = 16'($urandom);
        signed_mode = 1'($urandom); acc_en = 1'($urandom);
    endtask

    task automatic wait_done(input string name, output int nbusy, output int n);
        bit found;
        found = 0; nbusy = 0; n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            n++;
            if (done) found = 1;
            else if (busy) nbusy++;
        end
        check({name, "_timeout"}, 64'(found), 64'(1));
    endtask

    initial begin
        logic [31:0] pr;
        bit po;
        int nb, n, cnt_done;

        // Model pins against hand-computed results.
        ref_op(64'hFFFF, 64'hFFFF, 2, 8, 16, 0, 0, 0, pr, po);
        check("model_unsigned", {pr, 31'b0, po}, {32'h03FC, 32'h0});
        ref_op(64'h80FF, 64'h0102, 2, 8, 16, 1, 0, 0, pr, po);
        check("model_signed", {pr, 31'b0, po}, {32'hFF82, 32'h0});
        ref_op(64'h0101, 64'h0101, 2, 8, 16, 1, 1, 32'hFF82, pr, po);
        check("model_accum", {pr, 31'b0, po}, {32'hFF86, 32'h0});
        ref_op(64'hFFFF, 64'hFFFF, 2, 8, 9, 0, 0, 0, pr, po);
        check("model_wrap9", {pr, 31'b0, po}, {32'h01FC, 32'h1});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_state", {busy, done, ovf, rd}, 19'h0);

        launch(16'hFFFF, 16'hFFFF, 0, 0);
        wait_done("unsigned", nb, n);
        check("unsigned_busy_cycles", 64'(nb), 64'(3));
        check("unsigned_latency", 64'(n - 1), 64'(3));
        check("unsigned_rd", {rd, 15'b0, ovf}, {16'h03FC, 16'h0});

        launch(16'h80FF, 16'h0102, 1, 0);
        wait_done("signed", nb, n);
        check("signed_rd", {rd, 15'b0, ovf}, {16'hFF82, 16'h0});
        launch(16'h0101, 16'h0101, 1, 1);
        wait_done("accum", nb, n);
        check("accum_rd", {rd, 15'b0, ovf}, {16'hFF86, 16'h0});
        check("accum_done_gap", 64'(n - 1), 64'(3));

        launch(16'h1234, 16'h5678, 0, 0);
        @(negedge clk);
        rs = 16'hFFFF; rt = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored", nb, n);
        check("ignored_rd", {rd, 15'b0, ovf}, {16'h0114, 16'h0});
        cnt_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt_done++;
        end
        check("ignored_extra_done", 64'(cnt_done), 64'(0));

        launch(16'hFFFF, 16'hFFFF, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) cnt_done++;
            check("abort_busy_rd", {busy, rd}, 17'h0);
        end
        check("abort_no_done", 64'(cnt_done), 64'(0));

        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 2) == 0);
            rs = 16'($urandom); rt = 16'($urandom);
            signed_mode = 1'($urandom); acc_en = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rs = {$urandom_range(0, 1) ? 8'h80 : 8'h7F, $urandom_range(0, 1) ? 8'hFF : 8'h80};
                rt = rs;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);

        #1;
        rs9 = 16'hFFFF; rt9 = 16'hFFFF; start9 = 1'b1;
        @(posedge clk);
        #1 start9 = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !done9; i++) begin
            @(negedge clk);
            n++;
        end
        check("w9_done_seen", 64'(done9), 64'(1));
        check("w9_rd_ovf", {rd9, ovf9}, {9'h1FC, 1'b1});

        @(posedge clk);
        #1;
        rs32 = 32'h01020304; rt32 = 32'h05060708; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        nb = 0;
        for (int i = 0; i < 12 && !done32; i++) begin
            @(negedge clk);
            if (busy32) nb++;
        end
        check("w32_done_seen", 64'(done32), 64'(1));
        check("w32_busy_cycles", 64'(nb), 64'(5));
        check("w32_rd_ovf", {rd32, ovf32}, {16'h0024, 1'b0});

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
